// File: rtl/sync_pkg.sv
// Shared definitions for the sync tracker: lock FSM state encoding and
// the counter-width helper used to size the width/period measurements.
package sync_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } sync_state_t;

    // Wide enough to hold PERIOD_MAX+1, the value at which a period times out.
    function automatic int cnt_width(input int period_max);
        return $clog2(period_max + 2);
    endfunction

endpackage

// File: rtl/sync_synchronizer.sv
// Multi-flop synchroniser bringing the raw sync pin into the clk domain.
// All stages reset to 0 so the first observed level after reset is low.
module sync_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/sync_tracker.sv
// Sync line tracker: qualifies pulse width and trailing-edge period, follows
// pulse polarity and runs a SEARCH/ACQUIRE/LOCKED lock FSM with hysteresis.
module sync_tracker
    import sync_pkg::*;
#(
    parameter  int PULSE_MIN    = 10,
    parameter  int PULSE_MAX    = 20,
    parameter  int PERIOD_MIN   = 90,
    parameter  int PERIOD_MAX   = 110,
    parameter  int LOCK_COUNT   = 3,
    parameter  int UNLOCK_COUNT = 2,
    parameter  int SYNC_STAGES  = 2,
    localparam int CNT_W        = cnt_width(PERIOD_MAX)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             SyncIn,
    output logic             SyncOut,
    output logic             SyncValid,
    output logic             SyncPolarity,
    output logic [CNT_W-1:0] PulseWidth,
    output logic [CNT_W-1:0] Period,
    output logic [1:0]       Locked
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]  PW_MIN    = CNT_W'(PULSE_MIN);
    localparam logic [CNT_W-1:0]  PW_MAX    = CNT_W'(PULSE_MAX);
    localparam logic [CNT_W-1:0]  PER_MIN   = CNT_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0]  PER_MAX   = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0]  PER_TO    = CNT_W'(PERIOD_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_COUNT - 1);

    logic s;

    sync_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (CLK),
        .rst_n (nRST),
        .d     (SyncIn),
        .q     (s)
    );

    logic              s_d_q, s_d_d;
    logic              edge_q, edge_d;
    logic              first_q, first_d;
    logic [CNT_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    sync_state_t       state_q, state_d;
    logic              strobe_q, strobe_d;
    logic              valid_q, valid_d;
    logic              pol_q, pol_d;

    logic accept;
    logic pulse_pol;
    logic pol_change;
    logic period_good;
    logic timeout;
    logic miss;

    // edge_q is high in the first cycle of a new level, when level_q still
    // holds the length of the level that just ended.
    always_comb begin
        pulse_pol   = ~s_d_q;
        accept      = edge_q && !first_q && (level_q >= PW_MIN) && (level_q <= PW_MAX);
        pol_change  = accept && (pulse_pol != pol_q);
        timeout     = (per_cnt_q == PER_TO);
        period_good = accept && (per_cnt_q >= PER_MIN) && (per_cnt_q <= PER_MAX);
        miss        = timeout || (accept && !period_good);
    end

    always_comb begin
        s_d_d     = s;
        edge_d    = (s != s_d_q);
        first_d   = first_q;
        level_d   = level_q;
        per_cnt_d = per_cnt_q + 1'b1;
        width_d   = width_q;
        period_d  = period_q;
        pol_d     = pol_q;
        strobe_d  = accept;

        if (edge_q) begin
            level_d = CNT_ONE;
            first_d = 1'b0;
        end else if (level_q != '1) begin
            level_d = level_q + 1'b1;
        end

        // The restart cycle counts as one, so P equals the edge-to-edge spacing.
        if (accept || timeout) begin
            per_cnt_d = CNT_ONE;
        end

        if (accept) begin
            width_d = level_q;
            pol_d   = pulse_pol;
        end
        if (period_good) begin
            period_d = per_cnt_q;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        miss_d  = miss_q;
        case (state_q)
            ST_SEARCH: begin
                if (accept) begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (pol_change || miss) begin
                    good_d = '0;
                end else if (period_good) begin
                    if (good_q == GOOD_LAST) begin
                        state_d = ST_LOCKED;
                        miss_d  = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (pol_change) begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                end else if (period_good) begin
                    miss_d = '0;
                end else if (miss) begin
                    if (miss_q == MISS_LAST) begin
                        state_d = ST_SEARCH;
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_SEARCH;
        endcase
        valid_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s_d_q     <= 1'b0;
            edge_q    <= 1'b0;
            first_q   <= 1'b1;
            level_q   <= '0;
            per_cnt_q <= '0;
            width_q   <= '0;
            period_q  <= '0;
            good_q    <= '0;
            miss_q    <= '0;
            state_q   <= ST_SEARCH;
            strobe_q  <= 1'b0;
            valid_q   <= 1'b0;
            pol_q     <= 1'b0;
        end else begin
            s_d_q     <= s_d_d;
            edge_q    <= edge_d;
            first_q   <= first_d;
            level_q   <= level_d;
            per_cnt_q <= per_cnt_d;
            width_q   <= width_d;
            period_q  <= period_d;
            good_q    <= good_d;
            miss_q    <= miss_d;
            state_q   <= state_d;
            strobe_q  <= strobe_d;
            valid_q   <= valid_d;
            pol_q     <= pol_d;
        end
    end

    assign SyncOut      = strobe_q;
    assign SyncValid    = valid_q;
    assign SyncPolarity = pol_q;
    assign PulseWidth   = width_q;
    assign Period       = period_q;
    assign Locked       = state_q;

endmodule

// File: tb/tb_sync_tracker.sv
// Randomised scoreboard bench for sync_tracker: a level/period model predicts
// each accepted pulse; a monitor pops predictions on every SyncOut strobe.
module tb_sync_tracker;

    localparam int CW      = $clog2(110 + 2);
    localparam int W_MIN   = 10;
    localparam int W_MAX   = 20;
    localparam int P_MIN   = 90;
    localparam int P_MAX   = 110;
    localparam int TO      = P_MAX + 1;
    localparam int LOCK_N  = 3;
    localparam int UNLK_N  = 2;
    localparam int LAT     = 4;

    logic          CLK;
    logic          nRST;
    logic          SyncIn;
    logic          SyncOut;
    logic          SyncValid;
    logic          SyncPolarity;
    logic [CW-1:0] PulseWidth;
    logic [CW-1:0] Period;
    logic [1:0]    Locked;

    sync_tracker dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .SyncIn       (SyncIn),
        .SyncOut      (SyncOut),
        .SyncValid    (SyncValid),
        .SyncPolarity (SyncPolarity),
        .PulseWidth   (PulseWidth),
        .Period       (Period),
        .Locked       (Locked)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit pol;
        int width;
        int period;
        bit per_known;
        int state;
        int t_pin;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pin-level history plus the lock rules as plain integers.
    bit cur_lvl;
    int cur_start;
    bit first_lvl;
    bit have_last;
    int last_acc;
    int to_done;
    int m_state;
    int good_cnt;
    int miss_cnt;
    bit m_pol;
    int m_period;
    bit m_per_known;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        first_lvl   = 1'b1;
        cur_lvl     = 1'b0;
        cur_start   = cyc;
        have_last   = 1'b0;
        to_done     = 0;
        m_state     = 0;
        good_cnt    = 0;
        miss_cnt    = 0;
        m_pol       = 1'b0;
        m_period    = 0;
        m_per_known = 1'b1;
    endtask

    task automatic apply_timeout();
        if (m_state == 2) begin
            miss_cnt++;
            if (miss_cnt >= UNLK_N) m_state = 0;
        end else if (m_state == 1) begin
            good_cnt = 0;
        end
    endtask

    task automatic catch_up_timeouts(input int now);
        if (have_last) begin
            while (last_acc + TO * (to_done + 1) + LAT <= now) begin
                apply_timeout();
                to_done++;
            end
        end
    endtask

    task automatic model_accept(input int t, input bit pol, input int width);
        int  k;
        int  p;
        bit  good;
        bit  polchg;
        exp_t e;
        good = 1'b0;
        if (have_last) begin
            k = t - last_acc;
            while (to_done < (k - 1) / TO) begin
                apply_timeout();
                to_done++;
            end
            p    = ((k - 1) % TO) + 1;
            good = (p >= P_MIN) && (p <= P_MAX);
            if (good) begin
                m_period    = p;
                m_per_known = 1'b1;
            end
        end else begin
            p           = 0;
            m_per_known = 1'b0;
        end
        polchg = (pol != m_pol);
        case (m_state)
            0: begin
                m_state  = 1;
                good_cnt = 0;
            end
            1: begin
                if (polchg || !good) begin
                    good_cnt = 0;
                end else begin
                    good_cnt++;
                    if (good_cnt >= LOCK_N) begin
                        m_state  = 2;
                        miss_cnt = 0;
                    end
                end
            end
            default: begin
                if (polchg) begin
                    m_state  = 1;
                    good_cnt = 0;
                end else if (good) begin
                    miss_cnt = 0;
                end else begin
                    miss_cnt++;
                    if (miss_cnt >= UNLK_N) m_state = 0;
                end
            end
        endcase
        m_pol       = pol;
        e.pol       = pol;
        e.width     = width;
        e.period    = m_period;
        e.per_known = m_per_known;
        e.state     = m_state;
        e.t_pin     = t;
        sb_q.push_back(e);
        last_acc  = t;
        have_last = 1'b1;
        to_done   = 0;
    endtask

    task automatic level_end(input int t, input bit new_lvl);
        int len;
        len = t - cur_start;
        if (first_lvl) begin
            first_lvl = 1'b0;
        end else if (len >= W_MIN && len <= W_MAX) begin
            model_accept(t, cur_lvl, len);
        end
        cur_lvl   = new_lvl;
        cur_start = t;
    endtask

    // Called #1 after a rising edge; holds the pin at lvl for len clocks.
    task automatic drive(input bit lvl, input int len);
        if (lvl != cur_lvl) begin
            level_end(cyc, lvl);
            SyncIn = lvl;
        end
        repeat (len) @(posedge CLK);
        #1;
    endtask

    task automatic check_state(input string name);
        catch_up_timeouts(cyc);
        check({name, "_state"}, int'(Locked), m_state);
        check({name, "_valid"}, int'(SyncValid), (m_state == 2) ? 1 : 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_syncout"}, int'(SyncOut), 0);
        check({name, "_valid"}, int'(SyncValid), 0);
        check({name, "_polarity"}, int'(SyncPolarity), 0);
        check({name, "_width"}, int'(PulseWidth), 0);
        check({name, "_period"}, int'(Period), 0);
        check({name, "_state"}, int'(Locked), 0);
    endtask

    task automatic do_reset();
        drive(1'b0, 12);
        #2 nRST = 1'b0;
        #1 check_all_zero("in_reset");
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        model_reset();
    endtask

    task automatic pulse(input bit pol, input int width, input int period);
        drive(~pol, period - width);
        drive(pol, width);
    endtask

    always @(negedge CLK) begin
        if (nRST && SyncOut) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_strobe: got strobe width=%0d, expected none (cycle %0d)",
                         PulseWidth, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                $display("strobe cyc=%0d pin_t=%0d pol=%0d width=%0d period=%0d state=%0d",
                         cyc, mon_e.t_pin, SyncPolarity, PulseWidth, Period, Locked);
                check("strobe_latency", cyc - mon_e.t_pin, LAT);
                check("polarity", int'(SyncPolarity), int'(mon_e.pol));
                check("pulse_width", int'(PulseWidth), mon_e.width);
                if (mon_e.per_known) check("period", int'(Period), mon_e.period);
                check("state", int'(Locked), mon_e.state);
                check("sync_valid", int'(SyncValid), (mon_e.state == 2) ? 1 : 0);
            end
        end
    end

    localparam int N_DIR = 11;
    int dir_per[N_DIR] = '{100, 100, 89, 90, 110, 100, 111, 100, 111, 111, 100};
    int dir_wid[N_DIR] = '{15, 10, 20, 12, 18, 15, 15, 14, 16, 15, 15};

    initial begin
        nRST   = 1'b0;
        SyncIn = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 check_all_zero("power_on");
        do_reset();

        drive(1'b0, 500);
        check_all_zero("idle_500");

        for (int i = 0; i < 6; i++) pulse(1'b1, 15, 100);
        drive(1'b0, 10);
        check_state("pos_lock");
        check("pos_lock_fixed", int'(Locked), 2);

        // Out-of-range widths between good pulses: no strobe, lock held.
        drive(1'b0, 30);
        drive(1'b1, 9);
        drive(1'b0, 36);
        drive(1'b1, 15);
        drive(1'b0, 30);
        drive(1'b1, 21);
        drive(1'b0, 34);
        drive(1'b1, 15);
        drive(1'b0, 10);
        check_state("bad_width");

        drive(1'b0, 290);
        check_state("drop");
        check("drop_fixed", int'(Locked), 0);

        for (int i = 0; i < 5; i++) pulse(1'b1, 15, 100);
        drive(1'b0, 10);
        check_state("relock");

        for (int i = 0; i < 6; i++) begin
            drive(1'b1, (i == 0) ? 78 : 88);
            drive(1'b0, 12);
        end
        drive(1'b1, 10);
        check_state("neg_lock");
        check("neg_polarity", int'(SyncPolarity), 0);

        do_reset();
        drive(1'b0, 50);
        for (int i = 0; i < N_DIR; i++) pulse(1'b1, dir_wid[i], dir_per[i]);
        drive(1'b0, 10);
        check_state("period_edges");
        check("pending_directed", sb_q.size(), 0);

        for (int i = 0; i < 200; i++) begin
            bit pol;
            int w;
            int p;
            if (i == 0) pol = 1'b1;
            else if ($urandom_range(0, 7) == 0) pol = ~m_pol;
            else pol = m_pol;
            if (i == 0) pol = 1'b1;
            w = $urandom_range(8, 22);
            p = ($urandom_range(0, 15) == 0) ? 240 : $urandom_range(85, 115);
            if ($urandom_range(0, 49) == 0) do_reset();
            pulse(pol, w, p);
        end
        drive(~cur_lvl, 20);
        check_state("random_end");
        check("pending_final", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
